// File: rtl/step_pkg.sv
// step_pkg: shared definitions for the clock run/halt/single-step controller.
//   step_state_t   : FSM encoding (HALT=0, RUN=1, BURST=2)
//   CNT_W_DEF      : default burst length / remaining-edge counter width
//   DB_CYCLES_DEF  : default debounce window in clk cycles
package step_pkg;

  typedef enum logic [1:0] {
    HALT  = 2'd0,
    RUN   = 2'd1,
    BURST = 2'd2
  } step_state_t;

  localparam int CNT_W_DEF     = 8;
  localparam int DB_CYCLES_DEF = 16;

endpackage

// File: rtl/step_control_btn_sync.sv
// btn_sync: front end for one asynchronous front-panel button.
//   2-flop synchronizer -> optional debounce -> registered rising-edge pulse.
//   Debounce is compiled in only when STEP_CTRL_DEBOUNCE_EN is defined.
// Ports:
//   clk  in  ungated system clock
//   rst  in  asynchronous active-high reset
//   btn  in  raw asynchronous button level
//   ev   out one-cycle event pulse per accepted press
module btn_sync #(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic ev
);

  if (DB_CYCLES < 2) begin : g_db_check
    $error("btn_sync: DB_CYCLES must be >= 2");
  end

  logic sync_1, sync_2;
  logic vld_1, vld_2;   // sync_2 holds a real pin sample once vld_2 is set
  logic filt;
  logic filt_q;
  logic armed;          // set once the button has been seen released

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      vld_1  <= 1'b0;
      vld_2  <= 1'b0;
    end else begin
      sync_1 <= btn;
      sync_2 <= sync_1;
      vld_1  <= 1'b1;
      vld_2  <= vld_1;
    end
  end

`ifdef STEP_CTRL_DEBOUNCE_EN
  localparam int DB_W = $clog2(DB_CYCLES);

  logic [DB_W-1:0] db_cnt;
  logic            filt_r;

  // Filtered level follows the synced level only after it has differed for
  // DB_CYCLES consecutive cycles; any return to the filtered level restarts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt <= '0;
      filt_r <= 1'b0;
    end else if (sync_2 == filt_r) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
      db_cnt <= '0;
      filt_r <= sync_2;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

  assign filt = filt_r;
`else
  assign filt = sync_2;
`endif

  // The cleared synchronizer reads 0 right after reset, which would look like
  // a release. Arming waits for a genuine low sample so a button held through
  // reset release cannot fire until it is released and pressed again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q <= 1'b0;
      armed  <= 1'b0;
      ev     <= 1'b0;
    end else begin
      filt_q <= filt;
      armed  <= armed | (vld_2 & ~sync_2);
      ev     <= armed & filt & ~filt_q;
    end
  end

endmodule

// File: rtl/step_control.sv
// step_control: run/halt/single-step controller producing the registered
// enable for the positive-edge clock gate in front of the CPU clock tree.
// Optional button debounce: define STEP_CTRL_DEBOUNCE_EN.
// Ports:
//   clk        in  ungated system clock (same net as the edge gate)
//   rst        in  asynchronous active-high reset
//   run_btn    in  async button, each press toggles free-run
//   step_btn   in  async button, press while halted starts one burst
//   burst_len  in  edges per burst, sampled at burst start, 0 means 1
//   halt_req   in  synchronous halt from the CPU, overrides buttons
//   en         out registered enable: 1 passes the next clk rising edge
//   running    out high in RUN or BURST
//   step_rem   out edges remaining in the current burst, 0 outside BURST
//   fsm_state  out current FSM state for observation
module step_control
  import step_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_btn,
  input  logic             step_btn,
  input  logic [CNT_W-1:0] burst_len,
  input  logic             halt_req,
  output logic             en,
  output logic             running,
  output logic [CNT_W-1:0] step_rem,
  output step_state_t      fsm_state
);

  logic run_ev;
  logic step_ev;

  btn_sync #(.DB_CYCLES(DB_CYCLES)) u_run_sync (
    .clk (clk),
    .rst (rst),
    .btn (run_btn),
    .ev  (run_ev)
  );

  btn_sync #(.DB_CYCLES(DB_CYCLES)) u_step_sync (
    .clk (clk),
    .rst (rst),
    .btn (step_btn),
    .ev  (step_ev)
  );

  // en and running are registered alongside the state so en only changes just
  // after a rising edge and is stable for the whole period the gate samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_state <= HALT;
      en        <= 1'b0;
      running   <= 1'b0;
      step_rem  <= '0;
    end else if (halt_req) begin
      fsm_state <= HALT;
      en        <= 1'b0;
      running   <= 1'b0;
      step_rem  <= '0;
    end else begin
      case (fsm_state)
        HALT: begin
          if (run_ev) begin
            fsm_state <= RUN;
            en        <= 1'b1;
            running   <= 1'b1;
          end else if (step_ev) begin
            fsm_state <= BURST;
            en        <= 1'b1;
            running   <= 1'b1;
            step_rem  <= (burst_len == '0) ? CNT_W'(1) : burst_len;
          end
        end
        RUN: begin
          if (run_ev) begin
            fsm_state <= HALT;
            en        <= 1'b0;
            running   <= 1'b0;
          end
        end
        BURST: begin
          // step_rem counts the edge being passed this cycle; at 1 this is
          // the final edge, so drop en for the following cycle.
          if (step_rem <= CNT_W'(1)) begin
            fsm_state <= HALT;
            en        <= 1'b0;
            running   <= 1'b0;
            step_rem  <= '0;
          end else begin
            step_rem <= step_rem - CNT_W'(1);
          end
        end
        default: begin
          fsm_state <= HALT;
          en        <= 1'b0;
          running   <= 1'b0;
          step_rem  <= '0;
        end
      endcase
    end
  end

endmodule
